// File: rtl/alu_issue_unit.sv
// Clocked, back-pressurable front-end for an external combinational 32-bit ALU.
// Operands are held stable for SETTLE_CYCLES, then the ALU outputs are captured and returned.
module alu_issue_unit #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_cmd,
    output logic [31:0] operandA,
    output logic [31:0] operandB,
    output logic [2:0]  command,
    input  logic [31:0] result,
    input  logic        carryout,
    input  logic        zero,
    input  logic        overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_carryout,
    output logic        rsp_zero,
    output logic        rsp_overflow,
    output logic [2:0]  rsp_cmd,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       w_accept;

    // In RESP the slot frees on the same edge the response is consumed.
    assign req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
    assign w_accept  = req_valid && req_ready;

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // which is what lets a response retire and a new request load on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            operandA     <= '0;
            operandB     <= '0;
            command      <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_cmd      <= '0;
            op_count     <= '0;
        end else begin
            case (r_state)
                IDLE: ;
                SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        rsp_result   <= result;
                        rsp_carryout <= carryout;
                        rsp_zero     <= zero;
                        rsp_overflow <= overflow;
                        rsp_cmd      <= command;
                        rsp_valid    <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Acceptance overrides the RESP->IDLE transition for back-to-back issue.
            if (w_accept) begin
                operandA <= req_a;
                operandB <= req_b;
                command  <= req_cmd;
                r_cnt    <= CNT_LOAD;
                r_state  <= SETTLE;
            end
        end
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front-end for the 32-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand and command inputs from registers. It holds those inputs stable for a fixed settle window, then captures the ALU result and flags into a response register returned over a second valid/ready handshake. It sits directly upstream of the ALU, which it feeds, and directly downstream of it, consuming its outputs. This gives the rest of the datapath a clocked, back-pressurable ALU.

## Interface
- SETTLE_CYCLES, default 4: clock cycles from request acceptance to result capture; legal range 1..255.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_a  input  32  operand A.
- req_b  input  32  operand B.
- req_cmd  input  3  ALU command: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- operandA  output  32  registered operand A to ALU.
- operandB  output  32  registered operand B to ALU.
- command  output  3  registered command to ALU.
- result  input  32  ALU result.
- carryout  input  1  ALU carry flag.
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  32  captured result.
- rsp_carryout, rsp_zero, rsp_overflow  output  1 each  captured flags.
- rsp_cmd  output  3  command that produced the response.
- op_count  output  16  number of completed response handshakes.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid:
  - Register req_a, req_b and req_cmd into operandA, operandB and command.
  - Load the settle counter with SETTLE_CYCLES-1.
  - Go to SETTLE.
- SETTLE: req_ready=0; the counter decrements each cycle. In the cycle the counter reads 0, the next edge does all of the following:
  - Captures result, carryout, zero and overflow into the rsp_* registers.
  - Copies command into rsp_cmd.
  - Sets rsp_valid and goes to RESP.
- RESP: rsp_valid=1. All rsp_* outputs are held stable until rsp_valid&&rsp_ready. On that handshake:
  - rsp_valid clears.
  - op_count increments, wrapping 0xFFFF to 0x0000.
  - The FSM goes to IDLE.
- Overlap in RESP: req_ready = rsp_ready, combinational. If req_valid && rsp_ready in RESP, the response completes and a new request is accepted on the same edge. The FSM goes directly to SETTLE with the new operands.
- operandA, operandB and command change only on an acceptance edge. They hold their last values during SETTLE, RESP and IDLE.
- No arithmetic is done in this block. Flags and result pass through from the ALU unchanged, captured once per operation.
- Reset (rst_n low, any state, asynchronous):
  - State goes to IDLE and the counter clears.
  - operandA, operandB, command, rsp_result and rsp_cmd are 0.
  - rsp_valid, rsp_carryout, rsp_zero, rsp_overflow and op_count are 0.
  - An in-flight operation is dropped with no response. No request is accepted while rst_n is low.

## Timing
- Acceptance edge T0: operandA, operandB and command are valid after T0.
- Capture edge T0+SETTLE_CYCLES: rsp_valid is high after it. Request-to-response latency is SETTLE_CYCLES cycles.
- Sustained throughput with rsp_ready held high: one operation per SETTLE_CYCLES+1 cycles, using the RESP overlap.
- With rsp_ready low, the block stalls indefinitely in RESP with no loss and no output change.
- req_ready is a function of state and rsp_ready only. It never depends on req_valid.

## Test plan
- Reset: hold rst_n low 3 cycles -> all outputs 0 and req_ready=1 after release; assert rst_n low mid-SETTLE -> rsp_valid never rises and command returns to 000 immediately.
- ADD latency, SETTLE_CYCLES=4: req 0xFFFFFFFF+0xFFFFFFFF cmd 000 accepted at T0 -> rsp_valid rises after edge T0+4, rsp_result=0xFFFFFFFE, rsp_carryout=1, rsp_zero=0.
- SUB and zero flag: 300-100 -> rsp_result=200, rsp_zero=0; then 100-100 -> rsp_result=0, rsp_zero=1; rsp_cmd=001 both times.
- Backpressure: XOR 0x11C^0x1FF with rsp_ready low for 5 cycles -> rsp_result=0x0E3 stable, req_ready=0 throughout, op_count unchanged until the handshake, then +1.
- Back-to-back: AND then OR (0x11C, 0x1FF) with req_valid and rsp_ready held high -> second acceptance on the same edge as the first response handshake; responses 0x11C then 0x1FF, 5 cycles apart.
- Operand hold: change req_a/req_b every cycle during SETTLE and RESP -> operandA, operandB and command unchanged until the next acceptance edge.
